// File: rtl/if_fetch_stage.sv
// Instruction fetch stage.
// Holds the program counter (an 8-bit word address) and the IF/ID pipeline
// register. Instruction memory is read combinationally from the PC. The
// fetched word is registered into IF/ID on the following edge.
// Control inputs (stall, flush, redirect) only affect registered state, so
// none of them has a combinational path to an output.
module if_fetch_stage #(
    parameter logic [7:0]  RESET_PC  = 8'd0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_instr,
    output logic [7:0]  ifid_pc,
    output logic [7:0]  ifid_pc_plus1,
    output logic        ifid_valid,
    output logic [15:0] fetch_count
);

    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic       make_bubble;
    logic       load_ifid;

    // The +1 wraps naturally from 255 to 0; no overflow is reported.
    assign pc_plus1    = pc + 8'd1;
    assign imem_addr   = pc;
    // A taken redirect invalidates whatever was fetched this cycle, so it
    // squashes IF/ID exactly like an explicit flush.
    assign make_bubble = flush | redirect_valid;
    assign load_ifid   = ~make_bubble & ~stall;

    // PC update: reset, then redirect (beats a stall), then hold on stall,
    // otherwise step to the next word.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (!stall) begin
            pc <= pc_plus1;
        end
    end

    // IF/ID register: reset, then bubble, then hold on stall, otherwise
    // capture the word currently addressed by the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= 8'd0;
            ifid_pc_plus1 <= 8'd0;
            ifid_valid    <= 1'b0;
        end else if (make_bubble) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc_plus1;
            ifid_valid    <= 1'b0;
        end else if (!stall) begin
            ifid_instr    <= imem_data;
            ifid_pc       <= pc;
            ifid_pc_plus1 <= pc_plus1;
            ifid_valid    <= 1'b1;
        end
    end

    // Count real instructions accepted into IF/ID; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'd0;
        end else if (load_ifid && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. Memory model: mem[k] = 32'h1000_0000 + k.
// A second instance with RESET_PC = 254 shares the control inputs and is
// used for the PC wrap-around checks.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;

    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic [7:0]  ifid_pc_plus1;
    logic        ifid_valid;
    logic [15:0] fetch_count;

    logic [7:0]  w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_ifid_instr;
    logic [7:0]  w_ifid_pc;
    logic [7:0]  w_ifid_pc_plus1;
    logic        w_ifid_valid;
    logic [15:0] w_fetch_count;

    int n_compared = 0;
    int n_mismatched = 0;

    assign imem_data   = 32'h1000_0000 + {24'd0, imem_addr};
    assign w_imem_data = 32'h1000_0000 + {24'd0, w_imem_addr};

    if_fetch_stage #(.RESET_PC(8'd0), .NOP_INSTR(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus1  (ifid_pc_plus1),
        .ifid_valid     (ifid_valid),
        .fetch_count    (fetch_count)
    );

    if_fetch_stage #(.RESET_PC(8'd254), .NOP_INSTR(32'h0000_0000)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (w_imem_addr),
        .imem_data      (w_imem_data),
        .ifid_instr     (w_ifid_instr),
        .ifid_pc        (w_ifid_pc),
        .ifid_pc_plus1  (w_ifid_pc_plus1),
        .ifid_valid     (w_ifid_valid),
        .fetch_count    (w_fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [7:0] pc,
                              input logic valid, input logic [15:0] cnt, input logic [7:0] addr);
        check({tag, ".instr"}, ifid_instr, instr);
        check({tag, ".pc"}, {24'd0, ifid_pc}, {24'd0, pc});
        check({tag, ".pc1"}, {24'd0, ifid_pc_plus1}, {24'd0, pc + 8'd1});
        check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
        check({tag, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
        check({tag, ".addr"}, {24'd0, imem_addr}, {24'd0, addr});
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'd0;

        // Reset for two cycles.
        step();
        step();
        check("rst.instr", ifid_instr, 32'h0);
        check("rst.pc", {24'd0, ifid_pc}, 32'd0);
        check("rst.pc1", {24'd0, ifid_pc_plus1}, 32'd0);
        check("rst.valid", {31'd0, ifid_valid}, 32'd0);
        check("rst.count", {16'd0, fetch_count}, 32'd0);
        check("rst.addr", {24'd0, imem_addr}, 32'd0);
        check("wrap.rst_addr", {24'd0, w_imem_addr}, 32'd254);

        // Free-run four cycles; wrap instance checked alongside.
        rst = 1'b0;
        step();
        check_ifid("run0", 32'h1000_0000, 8'd0, 1'b1, 16'd1, 8'd1);
        check("wrap0.pc", {24'd0, w_ifid_pc}, 32'd254);
        check("wrap0.pc1", {24'd0, w_ifid_pc_plus1}, 32'd255);
        step();
        check_ifid("run1", 32'h1000_0001, 8'd1, 1'b1, 16'd2, 8'd2);
        check("wrap1.pc", {24'd0, w_ifid_pc}, 32'd255);
        check("wrap1.pc1", {24'd0, w_ifid_pc_plus1}, 32'd0);
        step();
        check_ifid("run2", 32'h1000_0002, 8'd2, 1'b1, 16'd3, 8'd3);
        check("wrap2.pc", {24'd0, w_ifid_pc}, 32'd0);
        check("wrap2.pc1", {24'd0, w_ifid_pc_plus1}, 32'd1);
        check("wrap2.instr", w_ifid_instr, 32'h1000_0000);
        step();
        check_ifid("run3", 32'h1000_0003, 8'd3, 1'b1, 16'd4, 8'd4);

        // Advance to PC=5, then stall three cycles.
        step();
        check_ifid("run4", 32'h1000_0004, 8'd4, 1'b1, 16'd5, 8'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("stall", 32'h1000_0004, 8'd4, 1'b1, 16'd5, 8'd5);
        end
        stall = 1'b0;
        step();
        check_ifid("unstall", 32'h1000_0005, 8'd5, 1'b1, 16'd6, 8'd6);
        step();
        check_ifid("run6", 32'h1000_0006, 8'd6, 1'b1, 16'd7, 8'd7);

        // Mid-stream reset with every other control asserted.
        rst = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'd99;
        step();
        check("mrst.instr", ifid_instr, 32'h0);
        check("mrst.pc", {24'd0, ifid_pc}, 32'd0);
        check("mrst.pc1", {24'd0, ifid_pc_plus1}, 32'd0);
        check("mrst.valid", {31'd0, ifid_valid}, 32'd0);
        check("mrst.count", {16'd0, fetch_count}, 32'd0);
        check("mrst.addr", {24'd0, imem_addr}, 32'd0);
        rst = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;

        // First edge after reset loads the word at RESET_PC.
        step();
        check_ifid("post_rst", 32'h1000_0000, 8'd0, 1'b1, 16'd1, 8'd1);
        step();
        step();
        check_ifid("run_b2", 32'h1000_0002, 8'd2, 1'b1, 16'd3, 8'd3);

        // Redirect to 10 at PC=3.
        redirect_valid = 1'b1;
        redirect_pc = 8'd10;
        step();
        check_ifid("redir", 32'h0, 8'd3, 1'b0, 16'd3, 8'd10);
        redirect_valid = 1'b0;
        step();
        check_ifid("redir_tgt", 32'h1000_000A, 8'd10, 1'b1, 16'd4, 8'd11);

        // Flush alone: bubble, PC advances.
        flush = 1'b1;
        step();
        check_ifid("flush", 32'h0, 8'd11, 1'b0, 16'd4, 8'd12);
        // Flush with stall: bubble, PC holds.
        stall = 1'b1;
        step();
        check_ifid("flush_stall", 32'h0, 8'd12, 1'b0, 16'd4, 8'd12);

        // Redirect + stall + flush to 20: redirect wins.
        redirect_valid = 1'b1;
        redirect_pc = 8'd20;
        step();
        check_ifid("redir_all", 32'h0, 8'd12, 1'b0, 16'd4, 8'd20);
        redirect_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        step();
        check_ifid("redir_all_tgt", 32'h1000_0014, 8'd20, 1'b1, 16'd5, 8'd21);

        // Redirect to the current PC refetches it.
        redirect_valid = 1'b1;
        redirect_pc = 8'd21;
        step();
        check_ifid("self_redir", 32'h0, 8'd21, 1'b0, 16'd5, 8'd21);
        redirect_valid = 1'b0;
        step();
        check_ifid("self_redir_tgt", 32'h1000_0015, 8'd21, 1'b1, 16'd6, 8'd22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
